aes_inv_subbytes_seq: RTL and testbench

Sequential AES InvSubBytes engine, the decryption-side counterpart of the forward SubBytes stage. It accepts one 128-bit state over a valid/ready handshake and applies the FIPS-197 inverse S-box to every byte, BYTES_PER_CYCLE bytes per clock, through a shared inverse S-box bank. It returns the result over a second valid/ready handshake. It sits in the decryption round datapath between InvShiftRows and AddRoundKey.

---
 rtl/aes_inv_subbytes_seq_if.sv | 21 ++
 rtl/aes_inv_subbytes_seq.sv | 132 +++++++++++++
 tb/tb_aes_inv_subbytes_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_subbytes_seq_if.sv
// Handshake bundle for the InvSubBytes engine: one input channel carrying the
// state to transform, one output channel returning the result, plus busy.
interface aes_inv_subbytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/aes_inv_subbytes_seq.sv
// Sequential AES InvSubBytes: one 128-bit state in, BYTES_PER_CYCLE inverse
// S-box lookups per clock starting at byte 0 (bits [127:120]), result out.
//
// state  | meaning
// IDLE   | waiting for a state, in_ready high
// BUSY   | substituting one byte group per clock
// DONE   | result on state_out, out_valid high until accepted
module aes_inv_subbytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    aes_inv_subbytes_seq_if.slave bus
);
    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    // Inverse S-box, entry 0x00 in the top byte so entry b sits at bit {~b, 3'b000}.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    // Configuration sanity check: the byte groups must tile the 16-byte state.
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_cfg
        initial $error("aes_inv_subbytes_seq: illegal BYTES_PER_CYCLE %0d", BYTES_PER_CYCLE);
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q;
    logic [127:0]        work_q, work_d;
    logic [127:0]        state_out_q;
    logic                last_step;
    logic                in_ready_c, out_valid_c, busy_c;
    logic [3:0]          grp_idx  [BYTES_PER_CYCLE];
    logic [7:0]          sub_byte [BYTES_PER_CYCLE];

    assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lut
        assign grp_idx[g]  = 4'(int'(step_q) * BYTES_PER_CYCLE + g);
        assign sub_byte[g] = inv_sbox(work_q[{~grp_idx[g], 3'b000} +: 8]);
    end

    // Working register with the current byte group substituted.
    always_comb begin
        work_d = work_q;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            work_d[{~grp_idx[g], 3'b000} +: 8] = sub_byte[g];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = S_BUSY;
            end
            S_BUSY: begin
                busy_c = 1'b1;
                if (last_step) state_d = S_DONE;
            end
            S_DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, substitute in BUSY, publish result on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            work_q      <= '0;
            state_out_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        work_q <= bus.state_in;
                        step_q <= '0;
                    end
                end
                S_BUSY: begin
                    work_q <= work_d;
                    step_q <= step_q + STEP_W'(1);
                    if (last_step) state_out_q <= work_d;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.state_out = state_out_q;
endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Directed bench for aes_inv_subbytes_seq: FIPS-197 vectors, edge bytes,
// backpressure, mid-operation reset, back-to-back and the width sweep.
module tb_aes_inv_subbytes_seq;
    localparam logic [127:0] C1_IN  = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] C1_OUT = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] ALL00  = 128'h0;
    localparam logic [127:0] ALL52  = {16{8'h52}};
    localparam logic [127:0] ALLFF  = {16{8'hff}};
    localparam logic [127:0] ALL7D  = {16{8'h7d}};
    localparam logic [127:0] ALL63  = {16{8'h63}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    aes_inv_subbytes_seq_if bus ();
    aes_inv_subbytes_seq_if b1 ();
    aes_inv_subbytes_seq_if b2 ();
    aes_inv_subbytes_seq_if b8 ();
    aes_inv_subbytes_seq_if b16 ();

    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(4))  dut     (.clk(clk), .rst_n(rst_n), .bus(bus));
    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(1))  dut_w1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(2))  dut_w2  (.clk(clk), .rst_n(rst_n), .bus(b2));
    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(8))  dut_w8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(16)) dut_w16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_drive(input logic v, input logic [127:0] d, input logic r);
        b1.in_valid = v;  b1.state_in = d;  b1.out_ready = r;
        b2.in_valid = v;  b2.state_in = d;  b2.out_ready = r;
        b8.in_valid = v;  b8.state_in = d;  b8.out_ready = r;
        b16.in_valid = v; b16.state_in = d; b16.out_ready = r;
    endtask

    // Offer one state from IDLE, return cycles until out_valid (40 = timed out).
    task automatic do_transfer(input logic [127:0] din, output logic [127:0] dout, output int lat);
        bus.in_valid = 1'b1;
        bus.state_in = din;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        dout = bus.state_out;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.state_out !== ALL00) begin n_fail++; $display("FAIL reset_state_out: got %h expected %h", bus.state_out, ALL00); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_c1();
        logic [127:0] d;
        int lat;
        bus.out_ready = 1'b1;
        do_transfer(C1_IN, d, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL c1_latency: got %0d expected 4", lat); end
        n_checks++; if (d !== C1_OUT) begin n_fail++; $display("FAIL c1_data: got %h expected %h", d, C1_OUT); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL c1_busy_done: got %b expected 1", bus.busy); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL c1_idle_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL c1_valid_drop: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.state_out !== C1_OUT) begin n_fail++; $display("FAIL c1_held: got %h expected %h", bus.state_out, C1_OUT); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL c1_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_edge_bytes();
        logic [127:0] vin [3];
        logic [127:0] vexp [3];
        logic [127:0] d;
        int lat;
        vin[0] = ALL00; vexp[0] = ALL52;
        vin[1] = ALLFF; vexp[1] = ALL7D;
        vin[2] = ALL63; vexp[2] = ALL00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_transfer(vin[i], d, lat);
            n_checks++; if (d !== vexp[i]) begin n_fail++; $display("FAIL edge_bytes_%0d: got %h expected %h", i, d, vexp[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        int lat;
        int bad_valid = 0;
        int bad_data = 0;
        int bad_ready = 0;
        bus.out_ready = 1'b0;
        do_transfer(ALL00, d, lat);
        n_checks++; if (d !== ALL52) begin n_fail++; $display("FAIL bp_data: got %h expected %h", d, ALL52); end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin bus.in_valid = 1'b1; bus.state_in = ALLFF; end
            if (i == 5) bus.in_valid = 1'b0;
            tick();
            if (bus.out_valid !== 1'b1) bad_valid++;
            if (bus.state_out !== ALL52) bad_data++;
            if (bus.in_ready !== 1'b0) bad_ready++;
        end
        n_checks++; if (bad_valid != 0) begin n_fail++; $display("FAIL bp_valid_hold: got %0d cycles low expected 0", bad_valid); end
        n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL bp_data_stable: got %0d cycles changed expected 0", bad_data); end
        n_checks++; if (bad_ready != 0) begin n_fail++; $display("FAIL bp_in_ready_low: got %0d cycles high expected 0", bad_ready); end
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); end
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_pulse_ignored: got busy %b expected 0", bus.busy); end
        n_checks++; if (bus.state_out !== ALL52) begin n_fail++; $display("FAIL bp_after_data: got %h expected %h", bus.state_out, ALL52); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.state_in = C1_IN;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.state_out !== ALL00) begin n_fail++; $display("FAIL rmid_state_out: got %h expected %h", bus.state_out, ALL00); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_transfer(C1_IN, d, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rmid_latency: got %0d expected 4", lat); end
        n_checks++; if (d !== C1_OUT) begin n_fail++; $display("FAIL rmid_data: got %h expected %h", d, C1_OUT); end
        tick();
    endtask

    task automatic test_back_to_back();
        int c;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.state_in = C1_IN;
        tick();
        bus.state_in = ALL00;
        c = 0;
        while (!bus.out_valid && c < 40) begin tick(); c++; end
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL b2b_lat1: got %0d expected 4", c); end
        n_checks++; if (bus.state_out !== C1_OUT) begin n_fail++; $display("FAIL b2b_data1: got %h expected %h", bus.state_out, C1_OUT); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: got %b expected 1", bus.busy); end
        c = 0;
        while (!bus.out_valid && c < 40) begin tick(); c++; end
        n_checks++; if (c !== 4) begin n_fail++; $display("FAIL b2b_lat2: got %0d expected 4", c); end
        n_checks++; if (bus.state_out !== ALL52) begin n_fail++; $display("FAIL b2b_data2: got %h expected %h", bus.state_out, ALL52); end
        tick();
    endtask

    task automatic test_param_sweep();
        int lat [4];
        logic [127:0] dat [4];
        int exp_lat [4];
        logic [3:0] ov;
        exp_lat[0] = 16; exp_lat[1] = 8; exp_lat[2] = 2; exp_lat[3] = 1;
        for (int k = 0; k < 4; k++) begin lat[k] = 99; dat[k] = '0; end
        sweep_drive(1'b1, C1_IN, 1'b1);
        tick();
        sweep_drive(1'b0, ALL00, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            tick();
            ov = {b16.out_valid, b8.out_valid, b2.out_valid, b1.out_valid};
            if (ov[0] && lat[0] == 99) begin lat[0] = c; dat[0] = b1.state_out; end
            if (ov[1] && lat[1] == 99) begin lat[1] = c; dat[1] = b2.state_out; end
            if (ov[2] && lat[2] == 99) begin lat[2] = c; dat[2] = b8.state_out; end
            if (ov[3] && lat[3] == 99) begin lat[3] = c; dat[3] = b16.state_out; end
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (lat[k] !== exp_lat[k]) begin n_fail++; $display("FAIL sweep_latency_%0d: got %0d expected %0d", k, lat[k], exp_lat[k]); end
            n_checks++; if (dat[k] !== C1_OUT) begin n_fail++; $display("FAIL sweep_data_%0d: got %h expected %h", k, dat[k], C1_OUT); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.state_in = '0;
        bus.out_ready = 1'b0;
        sweep_drive(1'b0, ALL00, 1'b0);
        test_reset();
        test_c1();
        test_edge_bytes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
